keyboard_decoder: RTL and testbench
===================================

// Module: keyboard_decoder
// PURPOSE
//  Consumes PS/2 set-2 scancode bytes from the PS/2 receiver. Tracks break/extended prefixes
//  and the shift/caps-lock/ctrl state, and reads the 1KB keymap ROM at {caps,shift,keycode}.
//  Emits one ASCII byte per key make with a valid/ready handshake to the terminal core.
//  Sits between the PS/2 receiver and the UART transmit path.
// PARAMETERS
//  CODE_BREAK  8'hF0  break prefix
//  CODE_EXT    8'hE0  extended prefix
//  CODE_LSHIFT 8'h12  left shift;  CODE_RSHIFT 8'h59 right shift
//  CODE_CAPS   8'h58  caps lock;   CODE_CTRL   8'h14 ctrl (plain or E0-prefixed)
// PORTS
//  clk            in   1  system clock
//  reset          in   1  synchronous, active-high reset
//  scancode_valid in   1  one-cycle strobe, scancode valid
//  scancode       in   8  PS/2 set-2 byte
//  rom_addr       out 10  to keymap ROM: {caps_lock, shift, keycode}
//  rom_dout       in   8  keymap ROM data, registered, 1-cycle read latency
//  ascii_valid    out  1  ascii holds a character
//  ascii          out  8  character byte
//  ascii_ready    in   1  consumer accepts when ascii_valid & ascii_ready
//  caps_lock      out  1  caps lock state (keyboard LED)
//  overflow       out  1  one-cycle pulse, character dropped
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; all modifier/held/pending flags clear.
//  States: IDLE, BRK, EXT, EXT_BRK, LOOKUP, LATCH.
//   IDLE:   F0 -> BRK; E0 -> EXT; 12/59 -> set that shift; 14 -> ctrl=1.
//           58 -> toggle caps_lock only if !caps_held; set caps_held.
//           any other code -> rom_addr<={caps_lock,lshift|rshift,code}, go LOOKUP.
//           Lookup uses the caps/shift value in effect before this byte.
//   BRK:    12/59 clear that shift; 14 clear ctrl; 58 clear caps_held; else no action -> IDLE.
//   EXT:    F0 -> EXT_BRK; 14 -> ctrl=1 -> IDLE; any other byte ignored -> IDLE.
//           (E0 arrow/nav keys produce no output.)
//   EXT_BRK: 14 -> ctrl=0; any byte -> IDLE.
//   LOOKUP: ROM samples rom_addr this edge -> LATCH.
//   LATCH:  sample rom_dout -> IDLE.
//           rom_dout==0: unmapped, no output.
//           Else c = (ctrl && rom_dout in 8'h40..8'h7F) ? rom_dout & 8'h1F : rom_dout.
//  Latency: make accepted at edge T -> ascii_valid high after edge T+2.
//   Prefix and modifier bytes are absorbed in 1 cycle.
//  Pending byte: scancode_valid during LOOKUP/LATCH is stored in a 1-entry pending register
//   and processed in IDLE on the cycle after LATCH. A second byte while pending is full is
//   dropped; overflow pulses.
//  Output: from LATCH, if !ascii_valid or (ascii_valid & ascii_ready) that cycle:
//   load ascii, set ascii_valid.
//   Else drop c; overflow pulses 1 cycle; held ascii unchanged.
//   ascii_valid clears on handshake unless reloaded the same cycle.
//   ascii is stable while ascii_valid is high.
//  Typematic repeat: repeated makes of a normal key each emit a char.
//   Repeated 58 does not re-toggle caps.
//  Reset mid-lookup: pending lookup and held char discarded; no output after reset.
//  rom_addr holds its last value outside LOOKUP.
// TESTING
//  1. Byte 1C, ROM[01C]=61 -> rom_addr=0x01C; ascii=0x61, valid 2 cycles later; held until ready.
//  2. 12,1C,F0,12,1C -> addr 0x11C then 0x01C; outputs 0x41 then 0x61.
//  3. 58,58,58,F0,58,1C -> caps_lock=1 (one toggle); addr 0x21C.
//     Then 12,1C -> addr 0x31C.
//  4. 14,21 (ROM=0x63) -> ascii 0x03. E0,14,21 -> 0x03.
//     E0,F0,14,21 -> 0x63. F0,1C -> no output.
//  5. ascii_ready=0, keys 1C then 32 -> ascii stays 0x61; overflow pulses once.
//     Ready=1 -> valid drops.
//  6. Assert reset during LATCH -> outputs 0, caps_lock=0, no char.
//     Bytes arriving during LOOKUP are processed in order via the pending register.

Source files
------------

// File: rtl/keyboard_decoder.sv
// PS/2 set-2 scancode to ASCII decoder: tracks prefixes and modifiers, looks up
// characters in an external keymap ROM and hands them out over valid/ready.
module keyboard_decoder #(
  parameter logic [7:0] CODE_BREAK  = 8'hF0,
  parameter logic [7:0] CODE_EXT    = 8'hE0,
  parameter logic [7:0] CODE_LSHIFT = 8'h12,
  parameter logic [7:0] CODE_RSHIFT = 8'h59,
  parameter logic [7:0] CODE_CAPS   = 8'h58,
  parameter logic [7:0] CODE_CTRL   = 8'h14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scancode_valid,
  input  logic [7:0] scancode,
  output logic [9:0] rom_addr,
  input  logic [7:0] rom_dout,
  output logic       ascii_valid,
  output logic [7:0] ascii,
  input  logic       ascii_ready,
  output logic       caps_lock,
  output logic       overflow
);

  typedef enum logic [2:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK,
    LOOKUP,
    LATCH
  } state_t;

  state_t     state_q, state_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic       ctrl_q, ctrl_d;
  logic       caps_q, caps_d;
  logic       caps_held_q, caps_held_d;
  logic [9:0] rom_addr_q, rom_addr_d;
  logic [7:0] ascii_q, ascii_d;
  logic       ascii_valid_q, ascii_valid_d;
  logic       pend_valid_q, pend_valid_d;
  logic [7:0] pend_code_q, pend_code_d;
  logic       overflow_q, overflow_d;

  logic       have_byte;
  logic [7:0] cur_byte;
  logic [7:0] char_c;

  // A byte parked while the ROM was busy always takes priority over the live input.
  assign have_byte = pend_valid_q | scancode_valid;
  assign cur_byte  = pend_valid_q ? pend_code_q : scancode;
  assign char_c    = (ctrl_q && (rom_dout[7:6] == 2'b01)) ? {3'b000, rom_dout[4:0]} : rom_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      lshift_q      <= 1'b0;
      rshift_q      <= 1'b0;
      ctrl_q        <= 1'b0;
      caps_q        <= 1'b0;
      caps_held_q   <= 1'b0;
      rom_addr_q    <= '0;
      ascii_q       <= '0;
      ascii_valid_q <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_code_q   <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      lshift_q      <= lshift_d;
      rshift_q      <= rshift_d;
      ctrl_q        <= ctrl_d;
      caps_q        <= caps_d;
      caps_held_q   <= caps_held_d;
      rom_addr_q    <= rom_addr_d;
      ascii_q       <= ascii_d;
      ascii_valid_q <= ascii_valid_d;
      pend_valid_q  <= pend_valid_d;
      pend_code_q   <= pend_code_d;
      overflow_q    <= overflow_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lshift_d      = lshift_q;
    rshift_d      = rshift_q;
    ctrl_d        = ctrl_q;
    caps_d        = caps_q;
    caps_held_d   = caps_held_q;
    rom_addr_d    = rom_addr_q;
    ascii_d       = ascii_q;
    ascii_valid_d = ascii_valid_q;
    pend_valid_d  = pend_valid_q;
    pend_code_d   = pend_code_q;
    overflow_d    = 1'b0;

    if (ascii_valid_q && ascii_ready) begin
      ascii_valid_d = 1'b0;
    end

    if ((state_q == LOOKUP) || (state_q == LATCH)) begin
      if (scancode_valid) begin
        if (!pend_valid_q) begin
          pend_valid_d = 1'b1;
          pend_code_d  = scancode;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end else if (pend_valid_q) begin
      pend_valid_d = scancode_valid;
      if (scancode_valid) begin
        pend_code_d = scancode;
      end
    end

    case (state_q)
      IDLE: begin
        if (have_byte) begin
          if (cur_byte == CODE_BREAK) begin
            state_d = BRK;
          end else if (cur_byte == CODE_EXT) begin
            state_d = EXT;
          end else if (cur_byte == CODE_LSHIFT) begin
            lshift_d = 1'b1;
          end else if (cur_byte == CODE_RSHIFT) begin
            rshift_d = 1'b1;
          end else if (cur_byte == CODE_CTRL) begin
            ctrl_d = 1'b1;
          end else if (cur_byte == CODE_CAPS) begin
            // Typematic repeats of caps lock must not toggle again.
            if (!caps_held_q) begin
              caps_d = ~caps_q;
            end
            caps_held_d = 1'b1;
          end else begin
            rom_addr_d = {caps_q, lshift_q | rshift_q, cur_byte};
            state_d    = LOOKUP;
          end
        end
      end
      BRK: begin
        if (have_byte) begin
          if (cur_byte == CODE_LSHIFT) begin
            lshift_d = 1'b0;
          end else if (cur_byte == CODE_RSHIFT) begin
            rshift_d = 1'b0;
          end else if (cur_byte == CODE_CTRL) begin
            ctrl_d = 1'b0;
          end else if (cur_byte == CODE_CAPS) begin
            caps_held_d = 1'b0;
          end
          state_d = IDLE;
        end
      end
      EXT: begin
        if (have_byte) begin
          if (cur_byte == CODE_BREAK) begin
            state_d = EXT_BRK;
          end else begin
            if (cur_byte == CODE_CTRL) begin
              ctrl_d = 1'b1;
            end
            state_d = IDLE;
          end
        end
      end
      EXT_BRK: begin
        if (have_byte) begin
          if (cur_byte == CODE_CTRL) begin
            ctrl_d = 1'b0;
          end
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        state_d = LATCH;
      end
      LATCH: begin
        state_d = IDLE;
        // A zero keymap entry marks an unmapped key.
        if (rom_dout != 8'h00) begin
          if (!ascii_valid_q || ascii_ready) begin
            ascii_d       = char_c;
            ascii_valid_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rom_addr    = rom_addr_q;
  assign ascii       = ascii_q;
  assign ascii_valid = ascii_valid_q;
  assign caps_lock   = caps_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_keyboard_decoder.sv
// Directed bench for keyboard_decoder with a behavioural keymap ROM and an
// expected-character scoreboard drained on every output handshake.
module tb_keyboard_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       scancodeValid;
  logic [7:0] scancode;
  logic [9:0] romAddr;
  logic [7:0] romDout;
  logic       asciiValid;
  logic [7:0] ascii;
  logic       asciiReady;
  logic       capsLock;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int overflowCount = 0;
  int ovBase;
  logic [7:0] expQ[$];

  always #5 clk = ~clk;

  keyboard_decoder dut (
    .clk           (clk),
    .reset         (reset),
    .scancode_valid(scancodeValid),
    .scancode      (scancode),
    .rom_addr      (romAddr),
    .rom_dout      (romDout),
    .ascii_valid   (asciiValid),
    .ascii         (ascii),
    .ascii_ready   (asciiReady),
    .caps_lock     (capsLock),
    .overflow      (overflow)
  );

  // Keymap: three letter keys, upper case when exactly one of caps/shift is set.
  function automatic logic [7:0] keymap(input logic [9:0] addr);
    logic [7:0] base;
    case (addr[7:0])
      8'h1C:   base = 8'h61;
      8'h32:   base = 8'h62;
      8'h21:   base = 8'h63;
      default: base = 8'h00;
    endcase
    if (base != 8'h00 && (addr[9] ^ addr[8])) base = base - 8'h20;
    return base;
  endfunction

  function automatic logic [7:0] expChar(input logic [9:0] addr, input logic ctrlOn);
    logic [7:0] k;
    k = keymap(addr);
    if (ctrlOn && k >= 8'h40 && k <= 8'h7F) k = k & 8'h1F;
    return k;
  endfunction

  always_ff @(posedge clk) romDout <= keymap(romAddr);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Handshake completes on the following posedge; inputs only change after posedges.
  always @(negedge clk) begin
    if (!reset && overflow) overflowCount++;
    if (!reset && asciiValid && asciiReady) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL unexpected char: observed 0x%0h expected none", ascii);
      end else begin
        checkOutput("ascii", {24'b0, ascii}, {24'b0, expQ.pop_front()});
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk);
    #1;
    scancodeValid = 1'b1;
    scancode      = b;
    @(posedge clk);
    #1;
    scancodeValid = 1'b0;
  endtask

  task automatic sendKey(input logic [7:0] code, input logic [9:0] expAddr, input logic ctrlOn);
    applyStimulus(code);
    checkOutput("rom_addr", {22'b0, romAddr}, {22'b0, expAddr});
    expQ.push_back(expChar(expAddr, ctrlOn));
    waitCycles(3);
  endtask

  initial begin
    reset         = 1'b1;
    scancodeValid = 1'b0;
    scancode      = 8'h00;
    asciiReady    = 1'b0;
    waitCycles(3);
    checkOutput("reset ascii_valid", {31'b0, asciiValid}, 32'd0);
    checkOutput("reset ascii", {24'b0, ascii}, 32'd0);
    checkOutput("reset caps_lock", {31'b0, capsLock}, 32'd0);
    checkOutput("reset overflow", {31'b0, overflow}, 32'd0);
    checkOutput("reset rom_addr", {22'b0, romAddr}, 32'd0);
    reset = 1'b0;

    $display("[TB] basic make, latency and hold");
    applyStimulus(8'h1C);
    checkOutput("rom_addr 1C", {22'b0, romAddr}, 32'h01C);
    expQ.push_back(8'h61);
    checkOutput("valid at T", {31'b0, asciiValid}, 32'd0);
    waitCycles(1);
    checkOutput("valid at T+1", {31'b0, asciiValid}, 32'd0);
    waitCycles(1);
    checkOutput("valid at T+2", {31'b0, asciiValid}, 32'd1);
    checkOutput("ascii at T+2", {24'b0, ascii}, 32'h61);
    waitCycles(3);
    checkOutput("valid held", {31'b0, asciiValid}, 32'd1);
    asciiReady = 1'b1;
    waitCycles(1);
    checkOutput("valid after handshake", {31'b0, asciiValid}, 32'd0);

    $display("[TB] shift");
    applyStimulus(8'h12);
    sendKey(8'h1C, 10'h11C, 1'b0);
    applyStimulus(8'hF0);
    applyStimulus(8'h12);
    sendKey(8'h1C, 10'h01C, 1'b0);

    $display("[TB] ctrl plain and extended");
    applyStimulus(8'h14);
    sendKey(8'h21, 10'h021, 1'b1);
    applyStimulus(8'hF0);
    applyStimulus(8'h14);
    applyStimulus(8'hE0);
    applyStimulus(8'h14);
    sendKey(8'h21, 10'h021, 1'b1);
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h14);
    sendKey(8'h21, 10'h021, 1'b0);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    waitCycles(4);
    checkOutput("no output on break", {31'b0, asciiValid}, 32'd0);
    checkOutput("rom_addr held", {22'b0, romAddr}, 32'h021);
    applyStimulus(8'hE0);
    applyStimulus(8'h75);
    waitCycles(4);
    checkOutput("no output on E0 key", {31'b0, asciiValid}, 32'd0);
    sendKey(8'h32, 10'h032, 1'b0);

    $display("[TB] caps lock");
    applyStimulus(8'h58);
    applyStimulus(8'h58);
    applyStimulus(8'h58);
    checkOutput("caps one toggle", {31'b0, capsLock}, 32'd1);
    applyStimulus(8'hF0);
    applyStimulus(8'h58);
    checkOutput("caps after release", {31'b0, capsLock}, 32'd1);
    sendKey(8'h1C, 10'h21C, 1'b0);
    applyStimulus(8'h12);
    sendKey(8'h1C, 10'h31C, 1'b0);
    applyStimulus(8'hF0);
    applyStimulus(8'h12);
    applyStimulus(8'h58);
    checkOutput("caps toggled off", {31'b0, capsLock}, 32'd0);
    applyStimulus(8'hF0);
    applyStimulus(8'h58);
    applyStimulus(8'h58);
    checkOutput("caps toggled on", {31'b0, capsLock}, 32'd1);
    applyStimulus(8'hF0);
    applyStimulus(8'h58);

    $display("[TB] backpressure drop");
    asciiReady = 1'b0;
    ovBase     = overflowCount;
    applyStimulus(8'h1C);
    checkOutput("rom_addr caps 1C", {22'b0, romAddr}, 32'h21C);
    expQ.push_back(expChar(10'h21C, 1'b0));
    waitCycles(3);
    applyStimulus(8'h32);
    waitCycles(3);
    checkOutput("held ascii unchanged", {24'b0, ascii}, 32'h41);
    checkOutput("held valid", {31'b0, asciiValid}, 32'd1);
    checkOutput("overflow pulses", overflowCount - ovBase, 32'd1);
    asciiReady = 1'b1;
    waitCycles(1);
    checkOutput("valid drops on ready", {31'b0, asciiValid}, 32'd0);

    $display("[TB] reset during LATCH");
    applyStimulus(8'h1C);
    waitCycles(1);
    reset = 1'b1;
    waitCycles(1);
    checkOutput("mid reset ascii_valid", {31'b0, asciiValid}, 32'd0);
    checkOutput("mid reset ascii", {24'b0, ascii}, 32'd0);
    checkOutput("mid reset caps_lock", {31'b0, capsLock}, 32'd0);
    checkOutput("mid reset rom_addr", {22'b0, romAddr}, 32'd0);
    reset = 1'b0;
    waitCycles(4);
    checkOutput("no char after reset", {31'b0, asciiValid}, 32'd0);

    $display("[TB] pending register");
    expQ.push_back(8'h61);
    expQ.push_back(8'h62);
    @(posedge clk); #1;
    scancodeValid = 1'b1;
    scancode      = 8'h1C;
    @(posedge clk); #1;
    scancode      = 8'h32;
    @(posedge clk); #1;
    scancodeValid = 1'b0;
    waitCycles(8);
    checkOutput("pending drained", expQ.size(), 32'd0);
    checkOutput("pending rom_addr", {22'b0, romAddr}, 32'h032);

    ovBase = overflowCount;
    expQ.push_back(8'h61);
    expQ.push_back(8'h62);
    @(posedge clk); #1;
    scancodeValid = 1'b1;
    scancode      = 8'h1C;
    @(posedge clk); #1;
    scancode      = 8'h32;
    @(posedge clk); #1;
    scancode      = 8'h21;
    @(posedge clk); #1;
    scancodeValid = 1'b0;
    waitCycles(8);
    checkOutput("pending full overflow", overflowCount - ovBase, 32'd1);
    checkOutput("pending full drained", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
